// File: rtl/hpdl1414_write_scheduler_pkg.sv
// Shared types and constants for the HPDL-1414 write scheduler.
// Used by the scheduler top, its round-robin picker and the bus interface.
package hpdl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_e;

    localparam logic [6:0] CHAR_SPACE  = 7'h20;
    localparam int         NUM_DIGITS  = 16;
    localparam int         DIGIT_IDX_W = 4;
    localparam int         CNT_W       = 8;

endpackage

// File: rtl/hpdl1414_write_scheduler_if.sv
// Host write port plus HPDL pad bus, shared by the command decoder and the scheduler.
interface hpdl1414_write_scheduler_if;
    import hpdl_pkg::*;

    logic                   WR_EN_i;
    logic [DIGIT_IDX_W-1:0] WR_ADDR_i;
    logic [6:0]             WR_DATA_i;
    logic                   CLR_i;
    logic                   BUSY_o;
    logic [6:0]             HPDL_D_o;
    logic [1:0]             HPDL_A_o;
    logic [3:0]             HPDL_WR_N_o;

    modport master (
        output WR_EN_i, WR_ADDR_i, WR_DATA_i, CLR_i,
        input  BUSY_o, HPDL_D_o, HPDL_A_o, HPDL_WR_N_o
    );

    modport slave (
        input  WR_EN_i, WR_ADDR_i, WR_DATA_i, CLR_i,
        output BUSY_o, HPDL_D_o, HPDL_A_o, HPDL_WR_N_o
    );

endinterface

// File: rtl/hpdl1414_write_scheduler_rr_pick.sv
// Combinational round-robin finder: first set dirty bit at or after ptr, wrapping 15->0.
module hpdl_rr_pick
    import hpdl_pkg::*;
(
    input  logic [NUM_DIGITS-1:0]  dirty,
    input  logic [DIGIT_IDX_W-1:0] ptr,
    output logic [DIGIT_IDX_W-1:0] idx,
    output logic                   valid
);

    always_comb begin
        logic [DIGIT_IDX_W-1:0] cand;
        valid = |dirty;
        idx   = ptr;
        cand  = ptr;
        // Scan from the farthest offset down so the nearest dirty entry wins.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            cand = ptr + DIGIT_IDX_W'(i);
            if (dirty[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/hpdl1414_write_scheduler.sv
// Shadow character buffer with dirty bits and a timed write-cycle sequencer
// driving four chained HPDL-1414 displays over a shared data/address bus.
module hpdl1414_write_scheduler
    import hpdl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 1
) (
    input  logic                       CLK_i,
    input  logic                       RST_i,
    hpdl1414_write_scheduler_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [6:0]             char_buf [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  dirty_q, dirty_d;
    logic [DIGIT_IDX_W-1:0] ptr_q, cur_q, pick_idx;
    logic                   pick_valid, take, done;
    logic                   rewritten_q, rewritten_d;
    logic [6:0]             data_q;
    logic [1:0]             addr_q;
    logic [3:0]             wr_n_q, wr_n_d;
    logic                   busy_q;

    hpdl_rr_pick u_pick (
        .dirty (dirty_q),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    take    = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Host updates are applied after the completion clear so a write landing on the
    // exit edge keeps its entry dirty.
    always_comb begin
        dirty_d = dirty_q;
        if (done && !rewritten_q) begin
            dirty_d[cur_q] = 1'b0;
        end
        if (bus.CLR_i) begin
            dirty_d = '1;
        end else if (bus.WR_EN_i) begin
            dirty_d[bus.WR_ADDR_i] = 1'b1;
        end

        rewritten_d = rewritten_q;
        if (take) begin
            rewritten_d = bus.CLR_i || (bus.WR_EN_i && (bus.WR_ADDR_i == pick_idx));
        end else if ((state_q != IDLE) &&
                     (bus.CLR_i || (bus.WR_EN_i && (bus.WR_ADDR_i == cur_q)))) begin
            rewritten_d = 1'b1;
        end

        wr_n_d = '1;
        if (state_d == PULSE) begin
            wr_n_d[cur_q[3:2]] = 1'b0;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dirty_q     <= '1;
            ptr_q       <= '0;
            cur_q       <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            wr_n_q      <= '1;
            busy_q      <= 1'b1;
            rewritten_q <= 1'b0;
            // NOTE: the buffer is reset on purpose: reset must leave every digit queued as a space so the panel blanks.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                char_buf[i] <= CHAR_SPACE;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dirty_q     <= dirty_d;
            rewritten_q <= rewritten_d;
            wr_n_q      <= wr_n_d;
            busy_q      <= (|dirty_d) || (state_d != IDLE);
            if (take) begin
                cur_q  <= pick_idx;
                data_q <= char_buf[pick_idx];
                addr_q <= pick_idx[1:0];
            end
            if (done) begin
                ptr_q <= cur_q + DIGIT_IDX_W'(1);
            end
            if (bus.CLR_i) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    char_buf[i] <= CHAR_SPACE;
                end
            end else if (bus.WR_EN_i) begin
                char_buf[bus.WR_ADDR_i] <= bus.WR_DATA_i;
            end
        end
    end

    assign bus.BUSY_o      = busy_q;
    assign bus.HPDL_D_o    = data_q;
    assign bus.HPDL_A_o    = addr_q;
    assign bus.HPDL_WR_N_o = wr_n_q;

endmodule

// File: tb/tb_hpdl1414_write_scheduler.sv
// Self-checking bench: slot-timer reference model plus a pad-level panel emulator.
module tb_hpdl1414_write_scheduler;
    import hpdl_pkg::*;

    localparam int S    = 2;
    localparam int P    = 3;
    localparam int H    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hpdl1414_write_scheduler_if bus ();

    hpdl1414_write_scheduler #(
        .SETUP_CYC (S),
        .PULSE_CYC (P),
        .HOLD_CYC  (H)
    ) dut (
        .CLK_i (clk),
        .RST_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: character store, pending set and one timed slot.
    logic [6:0] m_buf   [16];
    bit         m_dirty [16];
    int         m_ptr, m_cur, m_age;
    bit         m_active, m_rew;
    logic [6:0] m_d;
    logic [1:0] m_a;
    logic [3:0] m_wr_n;
    logic       m_busy;

    // Pad observer: emulated display contents and completed writes.
    logic [6:0] panel [16];
    int         wq_idx [$];
    logic [6:0] wq_dat [$];
    logic [3:0] prev_wr_n = 4'hF;
    logic [6:0] prev_d;
    logic [1:0] prev_a;
    int         low_len [4];
    bit         seen_5a;

    function automatic int model_pick();
        for (int k = 0; k < 16; k++) begin
            if (m_dirty[(m_ptr + k) % 16]) return (m_ptr + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit en, input bit clr,
                              input logic [3:0] addr, input logic [6:0] data);
        int j;
        bit any;
        if (r) begin
            for (int k = 0; k < 16; k++) begin
                m_buf[k]   = 7'h20;
                m_dirty[k] = 1'b1;
            end
            m_ptr = 0; m_cur = 0; m_age = 0; m_active = 0; m_rew = 0;
            m_d = '0; m_a = '0; m_wr_n = 4'hF; m_busy = 1'b1;
            return;
        end
        if (m_active) begin
            m_age++;
            if (m_age == S + P + H) begin
                if (!m_rew) m_dirty[m_cur] = 1'b0;
                m_ptr    = (m_cur + 1) % 16;
                m_active = 0;
            end
        end else begin
            j = model_pick();
            if (j >= 0) begin
                m_cur = j; m_d = m_buf[j]; m_a = 2'(j % 4);
                m_active = 1; m_age = 0; m_rew = 0;
            end
        end
        if (m_active && (clr || (en && (int'(addr) == m_cur)))) m_rew = 1;
        if (clr) begin
            for (int k = 0; k < 16; k++) begin
                m_buf[k]   = 7'h20;
                m_dirty[k] = 1'b1;
            end
        end else if (en) begin
            m_buf[addr]   = data;
            m_dirty[addr] = 1'b1;
        end
        m_wr_n = 4'hF;
        if (m_active && m_age >= S && m_age < S + P) m_wr_n[m_cur / 4] = 1'b0;
        any = 0;
        for (int k = 0; k < 16; k++) any |= m_dirty[k];
        m_busy = any || m_active;
    endtask

    task automatic tick(input bit r, input bit en, input bit clr,
                        input logic [3:0] addr, input logic [6:0] data);
        rst           = r;
        bus.WR_EN_i   = en;
        bus.CLR_i     = clr;
        bus.WR_ADDR_i = addr;
        bus.WR_DATA_i = data;
        model_step(r, en, clr, addr, data);
        @(posedge clk);
        @(negedge clk);
        n_tests += 5;
        if (bus.HPDL_WR_N_o !== m_wr_n) begin
            n_fail++;
            $display("FAIL wr_n t=%0t got %b expected %b", $time, bus.HPDL_WR_N_o, m_wr_n);
        end
        if (bus.HPDL_D_o !== m_d) begin
            n_fail++;
            $display("FAIL data t=%0t got %h expected %h", $time, bus.HPDL_D_o, m_d);
        end
        if (bus.HPDL_A_o !== m_a) begin
            n_fail++;
            $display("FAIL addr t=%0t got %h expected %h", $time, bus.HPDL_A_o, m_a);
        end
        if (bus.BUSY_o !== m_busy) begin
            n_fail++;
            $display("FAIL busy t=%0t got %b expected %b", $time, bus.BUSY_o, m_busy);
        end
        if ($countones(~bus.HPDL_WR_N_o) > 1) begin
            n_fail++;
            $display("FAIL wr_n_onehot t=%0t got %b expected at most one low", $time, bus.HPDL_WR_N_o);
        end
        if (r) begin
            for (int k = 0; k < 4; k++) low_len[k] = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.HPDL_WR_N_o[k] === 1'b0) begin
                    low_len[k]++;
                    if (bus.HPDL_D_o === 7'h5A) seen_5a = 1;
                end else if (prev_wr_n[k] === 1'b0) begin
                    n_tests++;
                    if (low_len[k] != P) begin
                        n_fail++;
                        $display("FAIL pulse_width disp=%0d got %0d expected %0d", k, low_len[k], P);
                    end
                    panel[k * 4 + prev_a] = prev_d;
                    wq_idx.push_back(k * 4 + prev_a);
                    wq_dat.push_back(prev_d);
                    low_len[k] = 0;
                end
            end
        end
        prev_wr_n = r ? 4'hF : bus.HPDL_WR_N_o;
        prev_d    = bus.HPDL_D_o;
        prev_a    = bus.HPDL_A_o;
    endtask

    task automatic idle_tick();
        tick(0, 0, 0, 4'd0, 7'd0);
    endtask

    task automatic drain(input int limit, output int cycles);
        cycles = 0;
        while (bus.BUSY_o !== 1'b0 && cycles < limit) begin
            idle_tick();
            cycles++;
        end
        n_tests++;
        if (bus.BUSY_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout got busy=%b after %0d cycles expected 0", bus.BUSY_o, cycles);
        end
    endtask

    task automatic wait_pulse(input string name);
        int n;
        n = 0;
        while (bus.HPDL_WR_N_o === 4'hF && n < 20) begin
            idle_tick();
            n++;
        end
        n_tests++;
        if (bus.HPDL_WR_N_o === 4'hF) begin
            n_fail++;
            $display("FAIL %s_pulse_timeout got no WR pulse expected one within 20 cycles", name);
        end
    endtask

    task automatic check_blank_sequence(input string name);
        int cyc;
        wq_idx.delete();
        wq_dat.delete();
        drain(300, cyc);
        n_tests += 2;
        if (cyc != 16 * (1 + S + P + H)) begin
            n_fail++;
            $display("FAIL %s_busy_fall got %0d expected %0d", name, cyc, 16 * (1 + S + P + H));
        end
        if (wq_idx.size() != 16) begin
            n_fail++;
            $display("FAIL %s_write_count got %0d expected 16", name, wq_idx.size());
        end
        for (int k = 0; k < 16 && k < wq_idx.size(); k++) begin
            n_tests++;
            if (wq_idx[k] != k || wq_dat[k] !== 7'h20) begin
                n_fail++;
                $display("FAIL %s_order[%0d] got idx=%0d d=%h expected idx=%0d d=20",
                         name, k, wq_idx[k], wq_dat[k], k);
            end
        end
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 4'd0, 7'd0);
        n_tests++;
        if (bus.HPDL_WR_N_o !== 4'hF || bus.HPDL_D_o !== 7'h00 ||
            bus.HPDL_A_o !== 2'b00 || bus.BUSY_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values got wr_n=%h d=%h a=%h busy=%b expected F 00 0 1",
                     bus.HPDL_WR_N_o, bus.HPDL_D_o, bus.HPDL_A_o, bus.BUSY_o);
        end
        check_blank_sequence("reset");
    endtask

    task automatic test_single_write();
        int cyc;
        wq_idx.delete();
        wq_dat.delete();
        tick(0, 1, 0, 4'd5, 7'h41);
        idle_tick();
        n_tests++;
        if (bus.HPDL_A_o !== 2'b01 || bus.HPDL_D_o !== 7'h41) begin
            n_fail++;
            $display("FAIL single_latch got a=%b d=%h expected a=01 d=41", bus.HPDL_A_o, bus.HPDL_D_o);
        end
        drain(50, cyc);
        n_tests++;
        if (wq_idx.size() != 1 || wq_idx[0] != 5 || wq_dat[0] !== 7'h41 || panel[5] !== 7'h41) begin
            n_fail++;
            $display("FAIL single_write got %0d writes panel5=%h expected one write idx5 d=41",
                     wq_idx.size(), panel[5]);
        end
    endtask

    task automatic test_rewrite();
        int cyc;
        wq_idx.delete();
        wq_dat.delete();
        tick(0, 1, 0, 4'd9, 7'h42);
        wait_pulse("rewrite");
        tick(0, 1, 0, 4'd9, 7'h43);
        drain(50, cyc);
        n_tests++;
        if (wq_idx.size() != 2 || wq_idx[0] != 9 || wq_dat[0] !== 7'h42 ||
            wq_idx[1] != 9 || wq_dat[1] !== 7'h43 || panel[9] !== 7'h43) begin
            n_fail++;
            $display("FAIL rewrite got %0d writes panel9=%h expected 9:42 then 9:43",
                     wq_idx.size(), panel[9]);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        int         exp_i [4] = '{2, 3, 14, 2};
        logic [6:0] exp_d [4] = '{7'h61, 7'h63, 7'h6E, 7'h62};
        wq_idx.delete();
        wq_dat.delete();
        tick(0, 1, 0, 4'd2, 7'h61);
        tick(0, 1, 0, 4'd2, 7'h62);
        tick(0, 1, 0, 4'd14, 7'h6E);
        tick(0, 1, 0, 4'd3, 7'h63);
        drain(80, cyc);
        n_tests++;
        if (wq_idx.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_count got %0d expected 4", wq_idx.size());
        end
        for (int k = 0; k < 4 && k < wq_idx.size(); k++) begin
            n_tests++;
            if (wq_idx[k] != exp_i[k] || wq_dat[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL wrap_order[%0d] got idx=%0d d=%h expected idx=%0d d=%h",
                         k, wq_idx[k], wq_dat[k], exp_i[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_clr_priority();
        int cyc;
        bit [15:0] hit;
        wq_idx.delete();
        wq_dat.delete();
        seen_5a = 0;
        hit = '0;
        tick(0, 1, 1, 4'd0, 7'h5A);
        drain(200, cyc);
        n_tests += 3;
        if (wq_idx.size() != 16 || wq_idx[0] != 3) begin
            n_fail++;
            $display("FAIL clr_count got %0d writes first=%0d expected 16 first=3",
                     wq_idx.size(), wq_idx.size() ? wq_idx[0] : -1);
        end
        for (int k = 0; k < wq_idx.size(); k++) begin
            if (wq_dat[k] === 7'h20) hit[wq_idx[k]] = 1'b1;
        end
        if (hit !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL clr_coverage got %h expected ffff", hit);
        end
        if (seen_5a) begin
            n_fail++;
            $display("FAIL clr_drop got 5A on bus expected never");
        end
    endtask

    task automatic test_reset_mid_pulse();
        tick(0, 1, 0, 4'd7, 7'h37);
        wait_pulse("midrst");
        tick(1, 0, 0, 4'd0, 7'd0);
        n_tests++;
        if (bus.HPDL_WR_N_o !== 4'hF) begin
            n_fail++;
            $display("FAIL midrst_wr_n got %b expected 1111", bus.HPDL_WR_N_o);
        end
        check_blank_sequence("midrst");
    endtask

    task automatic test_random();
        int cyc, r;
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 99));
            tick(0, r < 60, r < 2, 4'($urandom_range(0, 15)), 7'($urandom_range(33, 126)));
        end
        drain(400, cyc);
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (panel[k] !== m_buf[k]) begin
                n_fail++;
                $display("FAIL random_panel[%0d] got %h expected %h", k, panel[k], m_buf[k]);
            end
        end
    endtask

    initial begin
        bus.WR_EN_i   = 1'b0;
        bus.CLR_i     = 1'b0;
        bus.WR_ADDR_i = '0;
        bus.WR_DATA_i = '0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_rewrite();
        test_wrap();
        test_clr_priority();
        test_reset_mid_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
